// File: rtl/spi_slave.sv
// SPI responder for all four CKP/CKE modes; pins are oversampled by clk, MSB first both ways.
// Optional sticky TX-underrun flag is built only when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CKP,
    input  logic                  CKE,
    input  logic                  sck,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  overrun
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            sck_s;
    logic [1:0]            sel_s;
    logic [1:0]            mosi_s;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] tx_sh, rx_sh, tx_buf, load_word, rx_next;
    logic                  buf_full, miso_q, load, word_done;
    logic                  sel, sck_edge, lead, sample_edge, shift_edge, sampling, shifting;

    // Select is synchronised as active-high so the reset value means "deselected".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s  <= '0;
            sel_s  <= '0;
            mosi_s <= '0;
        end else begin
            sck_s  <= {sck_s[1:0], sck};
            sel_s  <= {sel_s[0], ~ss_n};
            mosi_s <= {mosi_s[0], mosi};
        end
    end

    assign sel         = sel_s[1];
    assign sck_edge    = sck_s[2] ^ sck_s[1];
    assign lead        = sck_s[1] ^ CKP;
    assign sample_edge = sck_edge & (lead ^ CKE);
    assign shift_edge  = sck_edge & ~(lead ^ CKE);
    assign sampling    = (state_q == ACTIVE) && sel && sample_edge;
    assign shifting    = (state_q == ACTIVE) && sel && shift_edge;
    assign rx_next     = {rx_sh[DATA_WIDTH-2:0], mosi_s[1]};
    assign load_word   = buf_full ? tx_buf : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (sample_edge && cnt == LAST) begin
                    word_done = 1'b1;
                    load      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A write landing with a load keeps the new word buffered; the load sees the old (empty) state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf   <= '0;
            buf_full <= 1'b0;
        end else if (tx_valid && !buf_full) begin
            tx_buf   <= tx_data;
            buf_full <= 1'b1;
        end else if (load) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state_q == IDLE && sel) begin
                cnt <= '0;
                // CKE=0 must show the MSB before the first SCK edge.
                if (!CKE) begin
                    miso_q <= load_word[DATA_WIDTH-1];
                    tx_sh  <= {load_word[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    miso_q <= 1'b0;
                    tx_sh  <= load_word;
                end
            end else if (state_q == ACTIVE && !sel) begin
                cnt    <= '0;
                miso_q <= 1'b0;
            end else if (sampling) begin
                rx_sh <= rx_next;
                if (word_done) begin
                    cnt      <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    tx_sh    <= load_word;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (shifting) begin
                miso_q <= tx_sh[DATA_WIDTH-1];
                tx_sh  <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign busy     = sel;
    assign miso_oe  = sel;
    assign miso     = sel & miso_q;
    assign tx_ready = ~buf_full;

`ifdef SPI_SLAVE_OVERRUN_EN
    logic ov_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ov_q <= 1'b0;
        else if (load && !buf_full) ov_q <= 1'b1;
    end
    assign overrun = ov_q;
`else
    assign overrun = 1'b0;
`endif

endmodule
